// File: rtl/lzc_pkg.sv
// Shared definitions for the pipelined leading/trailing zero counter:
// leaf pair encodings, count-width helper and the default result record.
package lzc_pkg;

  // Leaf encodings for one bit pair {hi, lo}, counted from the hi bit down.
  localparam logic [1:0] LEAF_HIGH_ONE  = 2'd0;
  localparam logic [1:0] LEAF_LOW_ONE   = 2'd1;
  localparam logic [1:0] LEAF_BOTH_ZERO = 2'd2;

  // Count width for an operand of the given width; it must be able to hold WIDTH itself.
  function automatic int lzc_cw(input int width);
    return $clog2(width) + 1;
  endfunction

  // Result record for the default 32-bit operand.
  typedef struct packed {
    logic                   zero;
    logic [lzc_cw(32)-1:0]  count;
  } lzc_result_t;

endpackage

// File: rtl/lzc_merge.sv
// One tree node: combines the counts of two adjacent halves of HALF bits each
// into the count for the 2*HALF-bit span above them. Purely combinational.
module lzc_merge #(
  parameter int  HALF = 2,
  localparam int IW   = $clog2(HALF) + 1,
  localparam int OW   = IW + 1
) (
  input  logic [IW-1:0] cnt_hi,
  input  logic          zero_hi,
  input  logic [IW-1:0] cnt_lo,
  input  logic          zero_lo,
  output logic [OW-1:0] cnt,
  output logic          zero
);

  // A fully zero high half passes the whole half plus whatever the low half counts.
  always_comb begin
    cnt  = {1'b0, cnt_hi};
    zero = 1'b0;
    if (zero_hi) begin
      cnt  = OW'(HALF) + {1'b0, cnt_lo};
      zero = zero_lo;
    end
  end

endmodule

// File: rtl/lzc_pipe.sv
// Pipelined zero counter: a registered binary tree, one register level per
// tree level, with a single global advance shared by all stages.
// Optional feature macro: LZC_PIPE_TZC_EN enables trailing-zero mode via in_mode
// (operand bit-reversed at capture); without it in_mode is ignored.
module lzc_pipe
  import lzc_pkg::*;
#(
  parameter int  WIDTH = 32,
  localparam int CW    = lzc_cw(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic          in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic          out_zero
);

  localparam int LV = $clog2(WIDTH);

  logic             adv;
  logic [WIDTH-1:0] op;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

`ifdef LZC_PIPE_TZC_EN
  // Trailing-zero mode reuses the leading-zero tree by mirroring the operand.
  always_comb begin
    op = in_data;
    if (in_mode) begin
      for (int i = 0; i < WIDTH; i++) op[i] = in_data[WIDTH-1-i];
    end
  end
`else
  logic unused_mode;
  assign unused_mode = in_mode;
  assign op          = in_data;
`endif

  genvar l, n;
  for (l = 0; l < LV; l++) begin : g_lvl
    localparam int NN = WIDTH >> (l + 1);
    localparam int NW = l + 2;

    logic [NN*NW-1:0] cnt_d, cnt_q;
    logic [NN-1:0]    zero_d, zero_q;
    logic             vld_d, vld_q;

    if (l == 0) begin : g_leaf
      for (n = 0; n < NN; n++) begin : g_node
        assign zero_d[n]          = (op[2*n+1 -: 2] == 2'b00);
        assign cnt_d[n*NW +: NW]  = op[2*n+1] ? LEAF_HIGH_ONE :
                                    op[2*n]   ? LEAF_LOW_ONE  : LEAF_BOTH_ZERO;
      end
      assign vld_d = in_valid;
    end else begin : g_tree
      localparam int PW = l + 1;
      for (n = 0; n < NN; n++) begin : g_node
        lzc_merge #(.HALF(1 << l)) u_merge (
          .cnt_hi  (g_lvl[l-1].cnt_q[(2*n+1)*PW +: PW]),
          .zero_hi (g_lvl[l-1].zero_q[2*n+1]),
          .cnt_lo  (g_lvl[l-1].cnt_q[(2*n)*PW +: PW]),
          .zero_lo (g_lvl[l-1].zero_q[2*n]),
          .cnt     (cnt_d[n*NW +: NW]),
          .zero    (zero_d[n])
        );
      end
      assign vld_d = g_lvl[l-1].vld_q;
    end

    // Stage register: data and valid move together, only when the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        zero_q <= '0;
        vld_q  <= 1'b0;
      end else if (adv) begin
        cnt_q  <= cnt_d;
        zero_q <= zero_d;
        vld_q  <= vld_d;
      end
    end
  end

  assign out_valid = g_lvl[LV-1].vld_q;
  assign out_count = g_lvl[LV-1].cnt_q;
  assign out_zero  = g_lvl[LV-1].zero_q[0];

endmodule

// File: tb/tb_lzc_pipe.sv
// Directed bench for lzc_pipe: 32-bit main instance plus 8- and 64-bit builds.
module tb_lzc_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  // 32-bit instance
  logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_zero;
  logic [31:0] in_data;
  logic [5:0]  out_count;

  // 8-bit instance
  logic        in_valid8, in_ready8, in_mode8, out_valid8, out_ready8, out_zero8;
  logic [7:0]  in_data8;
  logic [3:0]  out_count8;

  // 64-bit instance
  logic        in_valid64, in_ready64, in_mode64, out_valid64, out_ready64, out_zero64;
  logic [63:0] in_data64;
  logic [6:0]  out_count64;

  lzc_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_zero(out_zero));

  lzc_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_mode(in_mode8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_count(out_count8), .out_zero(out_zero8));

  lzc_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .in_data(in_data64), .in_mode(in_mode64), .out_valid(out_valid64),
    .out_ready(out_ready64), .out_count(out_count64), .out_zero(out_zero64));

  // Present one operand to the 32-bit pipe, measure cycles to out_valid, grab the result.
  task automatic drive32(input logic [31:0] d, input logic m,
                         output int lat, output logic [5:0] c, output logic z);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_mode = m; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_data = '0; lat = 1;
    while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
    c = out_count; z = out_zero;
    @(negedge clk);
  endtask

  task automatic drive8(input logic [7:0] d, output int lat, output logic [3:0] c, output logic z);
    @(negedge clk);
    in_valid8 = 1'b1; in_data8 = d;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0; lat = 1;
    while (!out_valid8 && lat < 30) begin @(negedge clk); lat++; end
    c = out_count8; z = out_zero8;
    @(negedge clk);
  endtask

  task automatic drive64(input logic [63:0] d, output int lat, output logic [6:0] c, output logic z);
    @(negedge clk);
    in_valid64 = 1'b1; in_data64 = d;
    @(posedge clk);
    @(negedge clk);
    in_valid64 = 1'b0; lat = 1;
    while (!out_valid64 && lat < 30) begin @(negedge clk); lat++; end
    c = out_count64; z = out_zero64;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; in_data = '0; in_mode = 0; out_ready = 1;
    in_valid8 = 0; in_data8 = '0; in_mode8 = 0; out_ready8 = 1;
    in_valid64 = 0; in_data64 = '0; in_mode64 = 0; out_ready64 = 1;
    #23;
    total++;
    if (out_valid !== 1'b0 || out_count !== 6'd0 || out_zero !== 1'b0)
      $display("[TB] FAIL reset_outputs: got valid=%b count=%0d zero=%b, want 0/0/0",
               out_valid, out_count, out_zero);
    else pass_cnt++;
    total++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b, want 1", in_ready);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("[TB] FAIL after_reset: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int lat; logic [5:0] c; logic z;
    drive32(32'h0000_0001, 1'b0, lat, c, z);
    total++;
    if (lat !== 5) $display("[TB] FAIL latency32: got %0d, want 5", lat); else pass_cnt++;
    total++;
    if (c !== 6'd31 || z !== 1'b0) $display("[TB] FAIL lzc_0x1: got %0d/%b, want 31/0", c, z);
    else pass_cnt++;
    drive32(32'h0000_0000, 1'b0, lat, c, z);
    total++;
    if (c !== 6'd32 || z !== 1'b1) $display("[TB] FAIL lzc_zero: got %0d/%b, want 32/1", c, z);
    else pass_cnt++;
    drive32(32'h8000_0000, 1'b0, lat, c, z);
    total++;
    if (c !== 6'd0 || z !== 1'b0) $display("[TB] FAIL lzc_msb: got %0d/%b, want 0/0", c, z);
    else pass_cnt++;
    drive32(32'h0001_F00F, 1'b0, lat, c, z);
    total++;
    if (c !== 6'd15 || z !== 1'b0) $display("[TB] FAIL lzc_mixed: got %0d/%b, want 15/0", c, z);
    else pass_cnt++;
  endtask

  task automatic test_mode();
    int lat; logic [5:0] c; logic z; logic [5:0] want1;
`ifdef LZC_PIPE_TZC_EN
    want1 = 6'd8;
`else
    want1 = 6'd23;
`endif
    drive32(32'h0000_0100, 1'b0, lat, c, z);
    total++;
    if (c !== 6'd23) $display("[TB] FAIL mode0_0x100: got %0d, want 23", c); else pass_cnt++;
    drive32(32'h0000_0100, 1'b1, lat, c, z);
    total++;
    if (c !== want1) $display("[TB] FAIL mode1_0x100: got %0d, want %0d", c, want1); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops [6];
    logic [5:0]  exp [6];
    int sent, got;
    logic acc, con;
    ops = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20};
    exp = '{6'd31, 6'd30, 6'd29, 6'd28, 6'd27, 6'd26};
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_mode = 1'b0;
      if (sent < 6) begin in_valid = 1'b1; in_data = ops[sent]; end
      else in_valid = 1'b0;
      #1;
      if (cyc == 5) begin
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
          $display("[TB] FAIL stall_in_ready: got in_ready=%b out_valid=%b, want 0/1", in_ready, out_valid);
        else pass_cnt++;
      end
      acc = in_valid && in_ready;
      con = out_valid && out_ready;
      if (con) begin
        total++;
        if (out_count !== exp[got])
          $display("[TB] FAIL b2b_out%0d: got %0d, want %0d", got, out_count, exp[got]);
        else pass_cnt++;
        got++;
      end
      if (acc) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (got !== 6) $display("[TB] FAIL b2b_count: got %0d results, want 6", got); else pass_cnt++;
    con = 1'b0;
    for (int k = 0; k < 8; k++) begin @(negedge clk); if (out_valid) con = 1'b1; end
    total++;
    if (con !== 1'b0) $display("[TB] FAIL b2b_extra: got extra output, want none"); else pass_cnt++;
  endtask

  task automatic test_reset_flush();
    logic [31:0] ops [3];
    int seen, k;
    logic [5:0] first;
    ops = '{32'h1, 32'h2, 32'h4};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = ops[i]; in_mode = 1'b0;
    end
    @(negedge clk); in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    total++;
    if (out_valid !== 1'b1 || out_count !== 6'd31)
      $display("[TB] FAIL flush_pre: got valid=%b count=%0d, want 1/31", out_valid, out_count);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_count !== 6'd31)
      $display("[TB] FAIL hold_stable: got valid=%b count=%0d, want 1/31", out_valid, out_count);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL async_flush: got valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_data = 32'h8000_0000;
    @(negedge clk); in_valid = 1'b0;
    seen = 0; first = 6'h3F;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) begin if (seen == 0) first = out_count; seen++; end
    end
    total++;
    if (seen !== 1 || first !== 6'd0)
      $display("[TB] FAIL flush_after: got %0d results first=%0d, want 1 result of 0", seen, first);
    else pass_cnt++;
  endtask

  task automatic test_widths();
    int lat; logic [3:0] c8; logic [6:0] c64; logic z; logic [63:0] d;
    for (int i = 0; i <= 8; i++) begin
      drive8((i == 8) ? 8'h00 : 8'(1 << i), lat, c8, z);
      total++;
      if (i == 8) begin
        if (c8 !== 4'd8 || z !== 1'b1 || lat !== 3)
          $display("[TB] FAIL w8_zero: got %0d/%b lat %0d, want 8/1 lat 3", c8, z, lat);
        else pass_cnt++;
      end else begin
        if (c8 !== 4'(7 - i) || z !== 1'b0 || lat !== 3)
          $display("[TB] FAIL w8_bit%0d: got %0d/%b lat %0d, want %0d/0 lat 3", i, c8, z, lat, 7 - i);
        else pass_cnt++;
      end
    end
    for (int i = 0; i <= 64; i++) begin
      d = (i == 64) ? 64'd0 : (64'd1 << i);
      drive64(d, lat, c64, z);
      total++;
      if (i == 64) begin
        if (c64 !== 7'd64 || z !== 1'b1 || lat !== 6)
          $display("[TB] FAIL w64_zero: got %0d/%b lat %0d, want 64/1 lat 6", c64, z, lat);
        else pass_cnt++;
      end else begin
        if (c64 !== 7'(63 - i) || z !== 1'b0 || lat !== 6)
          $display("[TB] FAIL w64_bit%0d: got %0d/%b lat %0d, want %0d/0 lat 6", i, c64, z, lat, 63 - i);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mode();
    test_back_to_back();
    test_reset_flush();
    test_widths();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/lzc_pipe.md
LZC_PIPE -- requirements
Module: lzc_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: input operand width; power of two, 8..64.
REQ-002 SHALL have local constant CW = log2(WIDTH)+1: count width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand presented.
REQ-006 SHALL have port in_ready  output  1  operand accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data  input  WIDTH  operand.
REQ-008 SHALL have port in_mode  input  1  0 = count leading zeros, 1 = count trailing zeros.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-011 SHALL have port out_count  output  CW  zero count.
REQ-012 SHALL have port out_zero  output  1  operand was all zeros.

Function
REQ-013 SHALL compute the count as a registered binary tree: leaf level encodes bit pairs (00->2, 01->1, 1x->0); each following level merges two halves; log2(WIDTH) register levels in total.
REQ-014 SHALL have a latency of exactly log2(WIDTH) cycles from acceptance to out_valid when out_ready stays high (WIDTH=32: 5 cycles).
REQ-015 SHALL sustain a throughput of one operand per cycle with no stall.
REQ-016 SHALL use a global advance = !out_valid || out_ready; in_ready = advance; all stages shift only on advance.
REQ-017 SHALL not collapse bubbles: the stage-valid bits shift with the data.
REQ-018 SHALL hold out_count/out_zero stable while out_valid && !out_ready.
REQ-019 SHALL drive out_count = WIDTH and out_zero = 1 for an all-zero operand; otherwise out_zero = 0 and out_count < WIDTH.
REQ-020 SHALL, when in_mode = 1, bit-reverse in_data at capture so the same tree yields the trailing-zero count; in_mode travels with the operand.
REQ-021 SHALL deliver results in acceptance order with no loss or duplication.
REQ-022 SHALL ignore in_data/in_mode when in_valid = 0; out_count content is don't-care when out_valid = 0.
REQ-023 SHALL accept a new operand in the same cycle an output is consumed at full pipeline.

Reset
REQ-024 SHALL, on rst_n low, clear all stage-valid bits immediately (asynchronously): out_valid = 0, out_count = 0, out_zero = 0.
REQ-025 SHALL drive in_ready = 1 during and after reset (pipe empty).
REQ-026 SHALL discard operands in flight when reset is asserted mid-stream; the first result after release belongs to the first operand accepted after release.

Configuration
REQ-027 SHALL honour the macro LZC_PIPE_TZC_EN: when defined, in_mode behaves per REQ-020.
REQ-028 SHALL, without LZC_PIPE_TZC_EN, keep the in_mode port, ignore it, and exclude the reversal logic; counts are always leading zeros.

Structure
REQ-029 SHALL put in package lzc_pkg: the leaf encoding constants, a constant function returning CW for a given width, and the result struct typedef (count, zero) for the default width.
REQ-030 SHALL implement one merge level as sub-module lzc_merge, parametrised by half-width.
REQ-031 SHALL let lzc_merge combine {zero_hi, cnt_hi}, {zero_lo, cnt_lo} into the next-level value: if the high half is all-zero, result = half-width + cnt_lo with the zero flag = zero_lo; else result = cnt_hi.
REQ-032 SHALL instantiate lzc_merge once per node via a generate loop; registers sit in lzc_pipe.

Verification
REQ-033 SHALL cover: WIDTH=32, in_data=0x0000_0001, mode 0 -> out_count=31, out_zero=0, out_valid exactly 5 cycles after acceptance.
REQ-034 SHALL cover: in_data=0x0000_0000 -> out_count=32, out_zero=1; in_data=0x8000_0000 -> out_count=0.
REQ-035 SHALL cover, with LZC_PIPE_TZC_EN defined: in_data=0x0000_0100, mode 1 -> out_count=8; same build, mode 0 -> 23; without the macro, mode 1 -> 23.
REQ-036 SHALL cover: 6 back-to-back operands 0x1,0x2,0x4,0x8,0x10,0x20 with out_ready low for cycles 3-5 -> in_ready low during the stall, outputs 31,30,29,28,27,26 in order, none lost.
REQ-037 SHALL cover: rst_n pulsed low with 3 operands in flight -> out_valid 0 in the same cycle; only operands accepted after release emerge.
REQ-038 SHALL cover: WIDTH=8 and WIDTH=64 builds, all single-bit operands plus zero -> correct counts, latency 3 and 6 cycles respectively.
